// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and baud divider math.
// Declarations only; no timing or flow control of its own.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Clocks per oversample tick, rounded down.
  function automatic int tick_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divide-by-DIV tick enable for UART rx/tx: tick is a registered 1-clk pulse every DIV clks.
// clr restarts the phase so the first tick lands a fixed delay after clr drops; no backpressure.
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 1");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with 2-of-3 mid-bit vote, false-start and break detection.
// Latency: data_valid 1 clk after the final stop vote; one-entry holding register, overrun when full.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SCW      = $clog2(OVERSAMPLE);
  localparam int BCW      = $clog2(DATA_BITS + 1);

  localparam logic [SCW-1:0] T_A   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] T_B   = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] T_V   = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] T_END = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS);

  if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || OVERSAMPLE > 16 ||
      (OVERSAMPLE % 2) != 0 || TICK_DIV < 1) begin : g_bad_cfg
    $error("uart_rx_cfg: unsupported configuration");
  end

  logic                 rx_meta, rx_s;
  rx_state_t            state;
  logic                 tick;
  logic [SCW-1:0]       s_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_first;
  logic                 stop_idx;

  logic vote, vote_now, bit_end, first_stop, last_stop, is_break, par_calc;

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    vote       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    vote_now   = tick && (s_cnt == T_V);
    bit_end    = tick && (s_cnt == T_END);
    first_stop = stop_idx ? stop_first : vote;
    last_stop  = (STOP_BITS == 1) || stop_idx;
    is_break   = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && !first_stop;
    par_calc   = 1'b0;
    if (PARITY == PAR_ODD)
      par_calc = ~(^shreg ^ par_bit);
    else if (PARITY == PAR_EVEN)
      par_calc = ^shreg ^ par_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      s_cnt      <= '0;
      bit_cnt    <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stop_first <= 1'b1;
      stop_idx   <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
      if (data_valid && data_ready)
        data_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          s_cnt    <= '0;
          bit_cnt  <= '0;
          stop_idx <= 1'b0;
          if (!rx_s)
            state <= ST_START;
        end
        ST_BREAK: begin
          if (rx_s)
            state <= ST_IDLE;
        end
        default: begin
          if (tick) begin
            s_cnt <= (s_cnt == T_END) ? '0 : s_cnt + 1'b1;
            if (s_cnt == T_A) samp_a <= rx_s;
            if (s_cnt == T_B) samp_b <= rx_s;
          end
          case (state)
            ST_START: begin
              if (vote_now && vote)
                state <= ST_IDLE;
              else if (bit_end)
                state <= ST_DATA;
            end
            ST_DATA: begin
              if (vote_now) begin
                shreg   <= {vote, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
              end
              if (bit_end && bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              end
            end
            ST_PARITY: begin
              if (vote_now) par_bit <= vote;
              if (bit_end)  state   <= ST_STOP;
            end
            ST_STOP: begin
              if (vote_now) begin
                if (!stop_idx) stop_first <= vote;
                // Leave half a bit early so the next start edge is never missed.
                if (last_stop) begin
                  state <= is_break ? ST_BREAK : ST_IDLE;
                  if (is_break) begin
                    break_det <= 1'b1;
                  end else if (!data_valid || data_ready) begin
                    data       <= shreg;
                    parity_err <= par_calc;
                    frame_err  <= ~first_stop;
                    data_valid <= 1'b1;
                  end else begin
                    overrun <= 1'b1;
                  end
                end else begin
                  stop_idx <= 1'b1;
                end
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and a 7E1 instance, directed frames, queue scoreboard per instance.
module tb_uart_rx_cfg;

  localparam int CLKF = 7_372_800;   // 4 clk per tick at 115200 x16
  localparam int BIT  = 64;          // clk per bit

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       rdy_a = 1'b1, rdy_b = 1'b1;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       vld_a, perr_a, ferr_a, ovr_a, brk_a, busy_a;
  logic       vld_b, perr_b, ferr_b, ovr_b, brk_b, busy_b;

  int tests = 0, fails = 0;
  int n_ovr_a = 0, n_brk_a = 0, n_ovr_b = 0, n_brk_b = 0;
  exp_t q_a[$], q_b[$];
  exp_t e_a, e_b;
  logic pv_a = 1'b0, phs_a = 1'b0, pv_b = 1'b0, phs_b = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(CLKF), .BAUD_RATE(115200), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .data(data_a), .data_valid(vld_a),
    .data_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun(ovr_a), .break_det(brk_a), .busy(busy_a));

  uart_rx_cfg #(.CLK_FREQ(CLKF), .BAUD_RATE(115200), .OVERSAMPLE(16),
                .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .data(data_b), .data_valid(vld_b),
    .data_ready(rdy_b), .parity_err(perr_b), .frame_err(ferr_b),
    .overrun(ovr_b), .break_det(brk_b), .busy(busy_b));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input bit to_b, input logic v);
    if (to_b) rx_b = v;
    else      rx_a = v;
  endtask

  // par: 0 none, 1 correct even parity, 2 inverted parity; glitch_bit < 0 means no glitch.
  task automatic send_char(input bit to_b, input logic [8:0] d, input int nbits,
                           input int par, input logic stop, input int glitch_bit);
    logic [8:0] mask;
    logic       p;
    mask = (9'd1 << nbits) - 9'd1;
    p = ^(d & mask);
    set_rx(to_b, 1'b0); wait_clk(BIT);
    for (int i = 0; i < nbits; i++) begin
      set_rx(to_b, d[i]);
      if (i == glitch_bit) begin
        wait_clk(BIT / 2);
        set_rx(to_b, ~d[i]); wait_clk(1);
        set_rx(to_b, d[i]);  wait_clk(BIT / 2 - 1);
      end else begin
        wait_clk(BIT);
      end
    end
    if (par != 0) begin
      set_rx(to_b, (par == 1) ? p : ~p); wait_clk(BIT);
    end
    set_rx(to_b, stop); wait_clk(BIT);
    set_rx(to_b, 1'b1); wait_clk(BIT);
  endtask

  always @(negedge clk) begin
    if (vld_a && (!pv_a || phs_a)) begin
      if (q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected: got data %h, no character expected", data_a);
      end else begin
        e_a = q_a.pop_front();
        check("a_data", 16'(data_a), 16'(e_a.d));
        check("a_parity_err", 16'(perr_a), 16'(e_a.pe));
        check("a_frame_err", 16'(ferr_a), 16'(e_a.fe));
      end
    end
    if (ovr_a) n_ovr_a++;
    if (brk_a) n_brk_a++;
    pv_a  = vld_a;
    phs_a = vld_a && rdy_a;
  end

  always @(negedge clk) begin
    if (vld_b && (!pv_b || phs_b)) begin
      if (q_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected: got data %h, no character expected", data_b);
      end else begin
        e_b = q_b.pop_front();
        check("b_data", 16'(data_b), 16'(e_b.d));
        check("b_parity_err", 16'(perr_b), 16'(e_b.pe));
        check("b_frame_err", 16'(ferr_b), 16'(e_b.fe));
      end
    end
    if (ovr_b) n_ovr_b++;
    if (brk_b) n_brk_b++;
    pv_b  = vld_b;
    phs_b = vld_b && rdy_b;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(4);
    check("rst_data", 16'(data_a), 16'h0);
    check("rst_valid", 16'(vld_a), 16'h0);
    check("rst_parity_err", 16'(perr_a), 16'h0);
    check("rst_frame_err", 16'(ferr_a), 16'h0);
    check("rst_overrun", 16'(ovr_a), 16'h0);
    check("rst_break", 16'(brk_a), 16'h0);
    check("rst_busy", 16'(busy_a), 16'h0);
    check("rst_b_valid", 16'(vld_b), 16'h0);
    rst = 1'b0;
    wait_clk(BIT);

    // 8N1 basic characters
    q_a.push_back('{9'h041, 1'b0, 1'b0}); send_char(1'b0, 9'h041, 8, 0, 1'b1, -1);
    q_a.push_back('{9'h0A5, 1'b0, 1'b0}); send_char(1'b0, 9'h0A5, 8, 0, 1'b1, -1);

    // 7E1 good parity then inverted parity
    q_b.push_back('{9'h055, 1'b0, 1'b0}); send_char(1'b1, 9'h055, 7, 1, 1'b1, -1);
    q_b.push_back('{9'h055, 1'b1, 1'b0}); send_char(1'b1, 9'h055, 7, 2, 1'b1, -1);

    // 0.3-bit low pulse is a false start
    rx_a = 1'b0; wait_clk(19);
    rx_a = 1'b1; wait_clk(BIT);
    check("false_start_busy", 16'(busy_a), 16'h0);

    // single-clk glitch inside data bit 3
    q_a.push_back('{9'h05A, 1'b0, 1'b0}); send_char(1'b0, 9'h05A, 8, 0, 1'b1, 3);

    // overrun with consumer stalled
    rdy_a = 1'b0;
    q_a.push_back('{9'h011, 1'b0, 1'b0}); send_char(1'b0, 9'h011, 8, 0, 1'b1, -1);
    send_char(1'b0, 9'h022, 8, 0, 1'b1, -1);
    check("overrun_count", 16'(n_ovr_a), 16'd1);
    check("overrun_held_data", 16'(data_a), 16'h011);
    check("overrun_held_valid", 16'(vld_a), 16'h1);
    rdy_a = 1'b1;
    wait_clk(2);
    check("drain_valid", 16'(vld_a), 16'h0);

    // break: two character times low
    rx_a = 1'b0; wait_clk(20 * BIT);
    rx_a = 1'b1; wait_clk(2 * BIT);
    check("break_count", 16'(n_brk_a), 16'd1);
    check("break_busy", 16'(busy_a), 16'h0);
    q_a.push_back('{9'h07E, 1'b0, 1'b0}); send_char(1'b0, 9'h07E, 8, 0, 1'b1, -1);

    // stop bit low with nonzero data
    q_a.push_back('{9'h03C, 1'b0, 1'b1}); send_char(1'b0, 9'h03C, 8, 0, 1'b0, -1);
    wait_clk(BIT);

    // reset in the middle of a data bit
    fork
      send_char(1'b0, 9'h0FF, 8, 0, 1'b1, -1);
      begin
        wait_clk(3 * BIT + 10);
        check("midframe_busy", 16'(busy_a), 16'h1);
        rst = 1'b1;
        wait_clk(1);
        check("midrst_data", 16'(data_a), 16'h0);
        check("midrst_valid", 16'(vld_a), 16'h0);
        check("midrst_frame_err", 16'(ferr_a), 16'h0);
        check("midrst_busy", 16'(busy_a), 16'h0);
        check("midrst_b_data", 16'(data_b), 16'h0);
        rst = 1'b0;
      end
    join
    q_a.push_back('{9'h00F, 1'b0, 1'b0}); send_char(1'b0, 9'h00F, 8, 0, 1'b1, -1);

    wait_clk(2 * BIT);
    check("a_all_delivered", 16'(q_a.size()), 16'd0);
    check("b_all_delivered", 16'(q_b.size()), 16'd0);
    check("a_total_overrun", 16'(n_ovr_a), 16'd1);
    check("a_total_break", 16'(n_brk_a), 16'd1);
    check("b_no_overrun", 16'(n_ovr_b), 16'd0);
    check("b_no_break", 16'(n_brk_b), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
